// File: rtl/fc_argmax.sv
// fc_argmax: streaming argmax over one frame of signed scores.
// Accepts cout beats on the din stream, tracks the running maximum with a
// strict compare (ties keep the earliest index), then presents index and value
// as one result beat on the res stream. Upstream is stalled while a result is held.
// Optional feature macro: FC_ARGMAX_TOP2_EN adds runner-up index and margin outputs.
module fc_argmax #(
   parameter int unsigned DW   = 16,
   parameter int unsigned IDXW = 12
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [IDXW-1:0] cout,
   input  logic            din_valid,
   output logic            din_ready,
   input  logic [DW-1:0]   din_data,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [IDXW-1:0] res_index,
   output logic [DW-1:0]   res_score
`ifdef FC_ARGMAX_TOP2_EN
   ,
   output logic [IDXW-1:0] res_index2,
   output logic [DW-1:0]   res_margin
`endif
);

   typedef enum logic {StAcc, StOut} state_e;

   state_e          state_q;
   logic [IDXW-1:0] cnt_q;
   logic [IDXW-1:0] len_q;
   logic [DW-1:0]   best_score_q;
   logic [IDXW-1:0] best_idx_q;

   logic            accept;
   logic            first;
   logic            last;
   logic            is_max;
   logic [IDXW-1:0] len_first;
   logic [DW-1:0]   best_score_d;
   logic [IDXW-1:0] best_idx_d;

`ifdef FC_ARGMAX_TOP2_EN
   localparam logic [DW-1:0] MaxPos = {1'b0, {(DW-1){1'b1}}};

   logic [DW-1:0]   sec_score_q, sec_score_d;
   logic [IDXW-1:0] sec_idx_q, sec_idx_d;
   logic            have2_q, have2_d;
   logic [DW:0]     diff;
   logic [DW-1:0]   margin_d;
   logic [IDXW-1:0] index2_d;
`endif

   // Candidate best for the beat currently offered; committed only on accept.
   always_comb begin
      accept       = din_valid & din_ready;
      first        = (cnt_q == '0);
      len_first    = (cout == '0) ? IDXW'(1) : cout;
      // On the first beat the length is checked against the value sampled now.
      last         = first ? (len_first == IDXW'(1)) : (cnt_q == len_q - IDXW'(1));
      is_max       = first || ($signed(din_data) > $signed(best_score_q));
      best_score_d = is_max ? din_data : best_score_q;
      best_idx_d   = is_max ? cnt_q : best_idx_q;
   end

`ifdef FC_ARGMAX_TOP2_EN
   // Runner-up candidate and saturated margin for the offered beat.
   always_comb begin
      sec_score_d = sec_score_q;
      sec_idx_d   = sec_idx_q;
      have2_d     = have2_q;
      if (first) begin
         sec_score_d = '0;
         sec_idx_d   = '0;
         have2_d     = 1'b0;
      end else if (is_max) begin
         // Displaced maximum drops to second place.
         sec_score_d = best_score_q;
         sec_idx_d   = best_idx_q;
         have2_d     = 1'b1;
      end else if (!have2_q || ($signed(din_data) > $signed(sec_score_q))) begin
         sec_score_d = din_data;
         sec_idx_d   = cnt_q;
         have2_d     = 1'b1;
      end
      // best >= runner-up always, so diff is non-negative and bit DW stays clear.
      diff     = {best_score_d[DW-1], best_score_d} - {sec_score_d[DW-1], sec_score_d};
      margin_d = MaxPos;
      if (have2_d && !diff[DW-1]) begin
         margin_d = diff[DW-1:0];
      end
      index2_d = have2_d ? sec_idx_d : '0;
   end
`endif

   // Frame accumulation and result handshake FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StAcc;
         din_ready    <= 1'b0;
         res_valid    <= 1'b0;
         res_index    <= '0;
         res_score    <= '0;
         cnt_q        <= '0;
         len_q        <= '0;
         best_score_q <= '0;
         best_idx_q   <= '0;
`ifdef FC_ARGMAX_TOP2_EN
         sec_score_q  <= '0;
         sec_idx_q    <= '0;
         have2_q      <= 1'b0;
         res_index2   <= '0;
         res_margin   <= '0;
`endif
      end else begin
         case (state_q)
            StAcc: begin
               din_ready <= 1'b1;
               if (accept) begin
                  best_score_q <= best_score_d;
                  best_idx_q   <= best_idx_d;
`ifdef FC_ARGMAX_TOP2_EN
                  sec_score_q  <= sec_score_d;
                  sec_idx_q    <= sec_idx_d;
                  have2_q      <= have2_d;
`endif
                  if (first) begin
                     len_q <= len_first;
                  end
                  if (last) begin
                     cnt_q     <= '0;
                     state_q   <= StOut;
                     din_ready <= 1'b0;
                     res_valid <= 1'b1;
                     res_index <= best_idx_d;
                     res_score <= best_score_d;
`ifdef FC_ARGMAX_TOP2_EN
                     res_index2 <= index2_d;
                     res_margin <= margin_d;
`endif
                  end else begin
                     cnt_q <= cnt_q + IDXW'(1);
                  end
               end
            end
            StOut: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  din_ready <= 1'b1;
                  state_q   <= StAcc;
               end
            end
            default: begin
               state_q <= StAcc;
            end
         endcase
      end
   end

endmodule
